fifo_read_port_arbiter: RTL and testbench
=========================================

// Module: fifo_read_port_arbiter
// PURPOSE
//  Read-domain controller for the I2C async FIFO. Consumes the synchronized Gray write pointer.
//  Owns the read pointer (binary + Gray), empty flag and fill level.
//  Shares the single FIFO read port between two requesters (0: I2C TX engine, 1: register-bus
//  debug read) with round-robin arbitration and a registered-RAM read handshake.
// PARAMETERS
//  addr_size   3   FIFO address width; depth = 2**addr_size; pointers are addr_size+1 bits
// PORTS
//  read_clock_i             in   1            read-domain clock
//  read_reset_n_i           in   1            asynchronous, active-low reset (read domain)
//  write_to_read_pointer_i  in   addr_size+1  Gray write pointer, already 2-flop synchronized
//  req_i                    in   2            read requests; bit n = requester n; level-held
//  grant_o                  out  2            one-hot grant; pulses 1 cycle, same cycle as read_en_o
//  read_en_o                out  1            FIFO RAM read enable
//  read_addr_o              out  addr_size    FIFO RAM read address (binary rptr[addr_size-1:0])
//  data_valid_o             out  2            one-hot; RAM data valid for requester n (1 cycle after grant)
//  read_pointer_o           out  addr_size+1  Gray read pointer, registered, to write-domain synchronizer
//  empty_o                  out  1            FIFO empty, registered
//  level_o                  out  addr_size+1  entries available = bin(wptr_sync) - rptr_bin, mod 2**(addr_size+1)
// BEHAVIOUR
//  Reset: async on read_reset_n_i low.
//   - Outputs: all 0, except empty_o=1.
//   - Internal: rptr_bin=0, last_grant=1 (requester 0 wins first), state=IDLE.
//  FSM states:
//   - IDLE: no read this cycle.
//   - READ: read_en_o=1, grant_o!=0.
//  Transitions (evaluated every cycle, from IDLE or READ):
//   - -> READ if (|req_i) && !empty_next_view, else -> IDLE.
//   - empty_next_view is the empty state after any read issued this cycle; back-to-back reads
//     at 1 per cycle are allowed.
//  Arbitration:
//   - Single requester: that requester wins.
//   - Both requesting: winner = ~last_grant (round-robin).
//   - last_grant updates only when a grant is issued.
//   - grant_o, read_en_o and read_addr_o are combinational from the registered state, stable
//     for the whole READ cycle.
//  On a grant:
//   - read_addr_o = current rptr_bin[addr_size-1:0].
//   - rptr_bin <= rptr_bin+1, wrapping over addr_size+1 bits.
//   - read_pointer_o <= gray(rptr_bin+1) = (b>>1)^b.
//  data_valid_o[n] asserts exactly 1 cycle after grant_o[n] (registered RAM latency 1).
//   - A requester must hold req_i until it sees its own grant.
//   - It must deassert req_i in the grant cycle (sampled next cycle) if it wants only one word.
//  empty_o <= (gray(rptr_bin_next) == write_to_read_pointer_i), evaluated every cycle.
//   - Never read when empty_o=1 or when the current read would make the FIFO empty.
//   - No grant is issued from a request that arrives while empty.
//  level_o <= bin(write_to_read_pointer_i) - rptr_bin_next. Gray-to-binary by XOR prefix.
//   - Range 0..2**addr_size.
//  Wrap-around:
//   - Pointer MSB toggles every depth reads.
//   - Empty/level remain correct across rptr_bin = 2**(addr_size+1)-1 -> 0.
//  Simultaneous write-pointer update and read in the same cycle:
//   - Both are used; level_o may stay unchanged.
//  Reset mid-READ: grant, valid and read_en drop asynchronously; the pointer returns to 0.
//   - The write domain must be reset together.
//  Pessimism: a synchronized wptr lagging 2 cycles only delays non-empty; never causes underflow.
// TESTING
//  1. Reset: release reset, wptr_sync=0 -> empty_o=1, level_o=0, grant_o=0, read_pointer_o=0.
//  2. Single read: wptr_sync=gray(1)=4'b0001, req_i=2'b01
//     - Cycle+1: empty_o=0, then grant_o=01, read_addr_o=0.
//     - Next cycle: data_valid_o=01, read_pointer_o=0001, empty_o=1.
//  3. Round-robin: wptr_sync=gray(4)=0110, req_i=11 held
//     - grants alternate 01,10,01,10 on consecutive cycles, read_addr_o=0,1,2,3.
//     - Then empty_o=1, grant_o stops.
//  4. Wrap: pre-fill/drain 15 entries, then write 2 more (wptr bin 17 mod 16 = 1)
//     - read_addr_o wraps 7 -> 0.
//     - read_pointer_o Gray sequence 1000 -> 0000 -> 0001.
//     - level_o decrements 2->1->0.
//  5. Full level: wptr_sync=gray(8)=1100, rptr=0, no req -> level_o=8, empty_o=0.
//  6. Reset mid-burst: assert read_reset_n_i low during READ
//     - grant_o, read_en_o, data_valid_o go 0 immediately.
//     - After release: rptr=0, empty_o=1, requester 0 wins first contended grant.

Source files
------------

// File: rtl/fifo_read_port_arbiter.sv
// rtl/fifo_read_port_arbiter.sv - read-domain pointer/flag logic with a two-requester round-robin read port
`timescale 1ns/1ps
module fifo_read_port_arbiter #(
  parameter int addr_size = 3
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_n_i,
  input  logic [addr_size:0]   write_to_read_pointer_i,
  input  logic [1:0]           req_i,
  output logic [1:0]           grant_o,
  output logic                 read_en_o,
  output logic [addr_size-1:0] read_addr_o,
  output logic [1:0]           data_valid_o,
  output logic [addr_size:0]   read_pointer_o,
  output logic                 empty_o,
  output logic [addr_size:0]   level_o
);

  typedef enum logic {IDLE, READ} state_t;

  state_t               state;
  logic [1:0]           grant_q;
  logic [1:0]           data_valid_q;
  logic                 last_grant;
  logic [addr_size:0]   rptr_bin;
  logic [addr_size:0]   rptr_gray;
  logic                 empty_q;
  logic [addr_size:0]   level_q;

  logic                 read_now;
  logic [addr_size:0]   rptr_bin_next;
  logic [addr_size:0]   rptr_gray_next;
  logic [addr_size:0]   wptr_bin;
  logic                 empty_next_view;
  logic                 issue;
  logic                 winner;

  function automatic logic [addr_size:0] gray2bin(input logic [addr_size:0] g);
    logic [addr_size:0] b;
    b[addr_size] = g[addr_size];
    for (int i = addr_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign read_now       = (state == READ);
  assign rptr_bin_next  = rptr_bin + {{addr_size{1'b0}}, read_now};
  assign rptr_gray_next = (rptr_bin_next >> 1) ^ rptr_bin_next;
  assign wptr_bin       = gray2bin(write_to_read_pointer_i);

  // Idle cycles trust the registered flag, so a request that arrives while
  // empty waits one cycle for the flag to clear before it can be granted.
  assign empty_next_view = read_now ? (rptr_gray_next == write_to_read_pointer_i) : empty_q;
  assign issue           = (|req_i) && !empty_next_view;

  always_comb begin
    winner = 1'b0;
    case (req_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
    if (!read_reset_n_i) begin
      state        <= IDLE;
      grant_q      <= 2'b00;
      data_valid_q <= 2'b00;
      last_grant   <= 1'b1;
      rptr_bin     <= '0;
      rptr_gray    <= '0;
      empty_q      <= 1'b1;
      level_q      <= '0;
    end else begin
      state        <= issue ? READ : IDLE;
      grant_q      <= issue ? (winner ? 2'b10 : 2'b01) : 2'b00;
      data_valid_q <= grant_q;
      if (issue) begin
        last_grant <= winner;
      end
      rptr_bin     <= rptr_bin_next;
      rptr_gray    <= rptr_gray_next;
      empty_q      <= (rptr_gray_next == write_to_read_pointer_i);
      level_q      <= wptr_bin - rptr_bin_next;
    end
  end

  assign grant_o        = grant_q;
  assign read_en_o      = read_now;
  assign read_addr_o    = rptr_bin[addr_size-1:0];
  assign data_valid_o   = data_valid_q;
  assign read_pointer_o = rptr_gray;
  assign empty_o        = empty_q;
  assign level_o        = level_q;

endmodule

// File: tb/tb_fifo_read_port_arbiter.sv
// tb/tb_fifo_read_port_arbiter.sv - scoreboard bench for fifo_read_port_arbiter
`timescale 1ns/1ps
module tb_fifo_read_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] wbin;
  logic [3:0] wptr;
  logic [1:0] req;
  logic [1:0] grant;
  logic       read_en;
  logic [2:0] read_addr;
  logic [1:0] data_valid;
  logic [3:0] read_pointer;
  logic       empty;
  logic [3:0] level;

  int compared = 0;
  int mismatched = 0;

  assign wptr = wbin ^ (wbin >> 1);

  fifo_read_port_arbiter #(.addr_size(3)) dut (
    .read_clock_i(clk),
    .read_reset_n_i(rst_n),
    .write_to_read_pointer_i(wptr),
    .req_i(req),
    .grant_o(grant),
    .read_en_o(read_en),
    .read_addr_o(read_addr),
    .data_valid_o(data_valid),
    .read_pointer_o(read_pointer),
    .empty_o(empty),
    .level_o(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes seen at the last edge, reads completed, last winner.
  typedef struct {int cyc; int id;} exp_t;
  exp_t       vq[$];
  int         cyc = 0;
  logic [3:0] w_at_edge;
  logic [1:0] req_at_edge;
  logic [3:0] reads_done;
  int         last_m;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    w_at_edge   <= wbin;
    req_at_edge <= req;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      reads_done = '0;
      last_m     = 1;
      vq.delete();
    end else begin
      logic [3:0] exp_level;
      int         g;
      exp_level = w_at_edge - reads_done;
      check("level", level, exp_level);
      check("empty", empty, exp_level == 0);
      check("rptr_gray", read_pointer, reads_done ^ (reads_done >> 1));
      if (vq.size() > 0 && vq[0].cyc == cyc) begin
        exp_t e;
        e = vq.pop_front();
        check("data_valid", data_valid, 2'b01 << e.id);
      end else begin
        check("data_valid_idle", data_valid, 2'b00);
      end
      check("read_en_vs_grant", read_en, grant != 2'b00);
      if (grant != 2'b00) begin
        check("grant_onehot", (grant == 2'b01) || (grant == 2'b10), 1);
        g = grant[1] ? 1 : 0;
        check("grant_has_data", exp_level >= 1, 1);
        check("grant_was_requested", req_at_edge[g], 1);
        if (req_at_edge == 2'b11) check("round_robin", g, 1 - last_m);
        last_m = g;
        check("read_addr", read_addr, reads_done[2:0]);
        vq.push_back('{cyc: cyc + 1, id: g});
        reads_done = reads_done + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wbin  = 4'd0;
    req   = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int words[2];
  int requested;
  int granted;
  int rate;
  int timeout;

  initial begin
    rst_n = 1'b0;
    wbin  = 4'd0;
    req   = 2'b00;
    tick();
    do_reset();

    // Reset state
    tick();
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_grant", grant, 0);
    check("rst_rptr", read_pointer, 0);
    check("rst_valid", data_valid, 0);

    // Single read: flag clears first, grant follows
    wbin = 4'd1;
    req  = 2'b01;
    tick();
    check("t2_empty_clear", empty, 0);
    check("t2_no_grant_yet", grant, 0);
    tick();
    check("t2_grant", grant, 2'b01);
    check("t2_addr", read_addr, 0);
    req = 2'b00;
    tick();
    check("t2_valid", data_valid, 2'b01);
    check("t2_rptr", read_pointer, 4'b0001);
    check("t2_empty_again", empty, 1);
    check("t2_grant_off", grant, 0);

    // Round robin over four entries
    do_reset();
    wbin = 4'd4;
    req  = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_grant", grant, (i % 2) ? 2'b10 : 2'b01);
      check("t3_addr", read_addr, i);
    end
    tick();
    check("t3_stop", grant, 0);
    check("t3_empty", empty, 1);
    req = 2'b00;

    // Full level
    do_reset();
    wbin = 4'd8;
    tick();
    tick();
    check("t5_level", level, 8);
    check("t5_empty", empty, 0);

    // Reset mid-burst
    do_reset();
    wbin = 4'd6;
    req  = 2'b11;
    tick();
    tick();
    tick();
    check("t6_in_read", read_en, 1);
    rst_n = 1'b0;
    wbin  = 4'd0;
    req   = 2'b00;
    #1;
    check("t6_grant_drop", grant, 0);
    check("t6_read_en_drop", read_en, 0);
    check("t6_valid_drop", data_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_rptr", read_pointer, 0);
    check("t6_empty", empty, 1);
    wbin = 4'd2;
    req  = 2'b11;
    tick();
    tick();
    check("t6_first_winner", grant, 2'b01);
    check("t6_addr", read_addr, 0);
    req = 2'b00;
    tick();
    tick();

    // Randomized traffic with wrap-around
    do_reset();
    words[0] = 0;
    words[1] = 0;
    requested = 0;
    granted = 0;
    rate = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rate = $urandom_range(0, 3);
      for (int n = 0; n < 2; n++) begin
        if (req[n] && grant[n]) begin
          granted++;
          words[n]--;
          if (words[n] == 0) req[n] = 1'b0;
        end else if (!req[n] && ($urandom % 4 == 0)) begin
          words[n] = $urandom_range(1, 4);
          requested += words[n];
          req[n] = 1'b1;
        end
      end
      if (((wbin - reads_done) & 4'hf) < 8 && ($urandom_range(0, 3) < rate)) wbin = wbin + 1;
      tick();
    end

    // Drain outstanding requests with the writer running
    timeout = 0;
    while (req != 2'b00 && timeout < 400) begin
      for (int n = 0; n < 2; n++) begin
        if (req[n] && grant[n]) begin
          granted++;
          words[n]--;
          if (words[n] == 0) req[n] = 1'b0;
        end
      end
      if (((wbin - reads_done) & 4'hf) < 8) wbin = wbin + 1;
      timeout++;
      tick();
    end
    check("drain_timeout", timeout < 400, 1);
    check("words_served", granted, requested);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
